// File: rtl/cpu_pkg.sv
// Shared encodings and defaults for the 4-bit CPU datapath blocks.
package cpu_pkg;

    localparam int unsigned CPU_WIDTH = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder1.sv
// Single-bit full adder cell; purely combinational.
module full_adder1 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum_c,
    output logic cout_c
);

    assign sum_c  = a ^ b ^ cin;
    assign cout_c = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial add/subtract sequencer: one shared full adder driven LSB-first over WIDTH cycles.
// Optional SERIAL_ALU_FLAGS_EN builds the ovf/zero flag logic; otherwise both flags read 0.
module serial_alu_seq
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = CPU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] sum_vec;
    logic             last_bit;

    full_adder1 u_fa (
        .a      (a_sh[0]),
        .b      (b_sh[0]),
        .cin    (carry),
        .sum_c  (fa_sum),
        .cout_c (fa_cout)
    );

    // acc keeps only the bits still needed; the new sum bit enters at the MSB
    assign sum_vec  = {fa_sum, acc};
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (start) state_n = ST_RUN;
            ST_RUN:  if (last_bit) state_n = ST_DONE;
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // busy/done are registered copies of the next state so they align with state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= (state_n == ST_RUN);
            done  <= (state_n == ST_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= (op_sub == OP_SUB) ? ~b : b;
                        carry <= op_sub;
                        cnt   <= '0;
                        acc   <= '0;
                    end
                end
                ST_RUN: begin
                    acc   <= sum_vec[WIDTH-1:1];
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    carry <= fa_cout;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        result <= sum_vec;
                        cout   <= fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ALU_FLAGS_EN
    logic c_msb_in;

    // carry into the MSB is captured one bit early so ovf = c_in(msb) ^ c_out(msb)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_msb_in <= 1'b0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
        end else if (state == ST_RUN) begin
            if (cnt == CW'(WIDTH - 2)) c_msb_in <= fa_cout;
            if (last_bit) begin
                ovf  <= fa_cout ^ c_msb_in;
                zero <= (sum_vec == '0);
            end
        end
    end
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed self-checking bench for serial_alu_seq at WIDTH=4.
module tb_serial_alu_seq;

`ifdef SERIAL_ALU_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       op_sub;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic       cout;
    logic       ovf;
    logic       zero;

    int         errors = 0;
    int         checks = 0;
    logic [3:0] last_res = 4'd0;

    serial_alu_seq #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_sub (op_sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one start pulse, then latency, held-result and output checks
    task automatic run_op(input string tag, input logic [3:0] ia, input logic [3:0] ib,
                          input logic isub, input logic [3:0] er, input logic ec,
                          input logic eo, input logic ez);
        int e;
        @(negedge clk);
        a = ia; b = ib; op_sub = isub; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~ia; b = ~ib; op_sub = ~isub;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_held"}, 32'(result), 32'(last_res));
        e = 0;
        while (!done && e < 20) begin
            @(negedge clk);
            e++;
        end
        check({tag, "_lat"}, 32'(e), 32'd4);
        check({tag, "_res"}, 32'(result), 32'(er));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_ovf"}, 32'(ovf), 32'(eo & FLAGS));
        check({tag, "_zero"}, 32'(zero), 32'(ez & FLAGS));
        check({tag, "_nbusy"}, 32'(busy), 32'd0);
        last_res = er;
    endtask

    initial begin
        int e;
        int n;
        rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; a = 4'd0; b = 4'd0;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res", 32'(result), 32'd0);
        check("rst_flags", 32'({cout, ovf, zero}), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        run_op("add3p5", 4'd3, 4'd5, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0);
        run_op("sub7m7", 4'd7, 4'd7, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1);
        run_op("add15p1", 4'd15, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        run_op("sub2m5", 4'd2, 4'd5, 1'b1, 4'd13, 1'b0, 1'b0, 1'b0);
        run_op("sub8m1", 4'd8, 4'd1, 1'b1, 4'd7, 1'b1, 1'b1, 1'b0);

        // start during RUN must be ignored
        @(negedge clk);
        a = 4'd1; b = 4'd1; op_sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 4'd9; b = 4'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) n++;
            @(negedge clk);
        end
        check("ign_dones", 32'(n), 32'd1);
        check("ign_res", 32'(result), 32'd2);
        last_res = 4'd2;

        // asynchronous reset mid-RUN
        @(negedge clk);
        a = 4'd3; b = 4'd5; op_sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_res", 32'(result), 32'd0);
        check("arst_flags", 32'({cout, ovf, zero}), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        last_res = 4'd0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy || done) n++;
        end
        check("post_rst_idle", 32'(n), 32'd0);
        run_op("post_rst_add", 4'd6, 4'd1, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0);

        // start held high: one operation every WIDTH+2 cycles
        @(negedge clk);
        a = 4'd4; b = 4'd4; op_sub = 1'b0; start = 1'b1;
        e = 0;
        while (!done && e < 20) begin
            @(negedge clk);
            e++;
        end
        check("hold_first", 32'(e), 32'd5);
        for (int r = 0; r < 2; r++) begin
            e = 0;
            do begin
                @(negedge clk);
                e++;
            end while (!done && e < 20);
            check("hold_period", 32'(e), 32'd6);
            check("hold_res", 32'(result), 32'd8);
            check("hold_flags", 32'({ovf, zero}), 32'({FLAGS, 1'b0}));
        end
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("hold_end_idle", 32'({busy, done}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
